// File: rtl/lspc_pkg.sv
// Shared LSPC definitions: register word offsets, MODE bit positions and
// IRQ acknowledge bit positions used by the interrupt/timer controller.
package lspc_pkg;

    typedef enum logic [2:0] {
        LSPC_REG_MODE   = 3'd3,
        LSPC_REG_RLD_HI = 3'd4,
        LSPC_REG_RLD_LO = 3'd5,
        LSPC_REG_ACK    = 3'd6,
        LSPC_REG_TSTOP  = 3'd7
    } lspc_reg_e;

    localparam int MODE_AA_DIS    = 3;
    localparam int MODE_TIRQ_EN   = 4;
    localparam int MODE_RLD_WR    = 5;
    localparam int MODE_RLD_FRAME = 6;
    localparam int MODE_RLD_ZERO  = 7;

    localparam int ACK_RESET = 0;
    localparam int ACK_TIMER = 1;
    localparam int ACK_VBL   = 2;

endpackage

// File: rtl/lspc_timer_cnt.sv
// Programmable raster timer counter. Loads have priority over ticking:
// write reload, then frame reload, then zero-hit reload/wrap or decrement.
module lspc_timer_cnt #(
    parameter int TIMER_W = 32
) (
    input  logic               CLK,
    input  logic               RESETP,
    input  logic               wr_ld,
    input  logic [TIMER_W-1:0] wr_val,
    input  logic               frame_ld,
    input  logic [TIMER_W-1:0] reload,
    input  logic               rld_zero,
    input  logic               tick,
    input  logic               stop,
    output logic               zero_hit,
    output logic [TIMER_W-1:0] count
);
    import lspc_pkg::*;

    logic tick_ok;

    assign tick_ok  = tick && !stop;
    assign zero_hit = tick_ok && (count == '0);

    // Counter register: loads override ticks; a zero-hit reloads or wraps.
    always_ff @(posedge CLK or negedge RESETP) begin
        if (!RESETP) begin
            count <= '0;
        end else if (wr_ld) begin
            count <= wr_val;
        end else if (frame_ld) begin
            count <= reload;
        end else if (zero_hit) begin
            count <= rld_zero ? reload : '1;
        end else if (tick_ok) begin
            count <= count - {{(TIMER_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/lspc_irq_timer_ctrl.sv
// LSPC configuration and interrupt controller: MODE/RELOAD/ACK register
// decode, auto-animation controls, raster timer and the three IRQ flags.
// Optional build macro LSPC_TIMER_STOP_EN adds the TSTOP register that
// freezes the timer during PAL border lines.
module lspc_irq_timer_ctrl
    import lspc_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic        CLK,
    input  logic        RESETP,
    input  logic        PCK_EN,
    input  logic        FRAME_START,
    input  logic        PAL_BORDER,
    input  logic        WR,
    input  logic [2:0]  ADDR,
    input  logic [15:0] DIN,
    output logic [7:0]  AA_SPEED,
    output logic        AA_DISABLE,
    output logic [3:0]  TIMER_MODE,
    output logic        IRQ_TIMER,
    output logic        IRQ_VBL,
    output logic        IRQ_RESET
);

    logic [15:0]        mode_q;
    logic [TIMER_W-1:0] reload_q;
    logic               wr_mode, wr_rld_hi, wr_rld_lo, wr_ack;
    logic [2:0]         ack;
    logic               zero_hit;
    logic               stop;
    logic [TIMER_W-1:0] count;

    assign wr_mode   = WR && (ADDR == LSPC_REG_MODE);
    assign wr_rld_hi = WR && (ADDR == LSPC_REG_RLD_HI);
    assign wr_rld_lo = WR && (ADDR == LSPC_REG_RLD_LO);
    assign wr_ack    = WR && (ADDR == LSPC_REG_ACK);
    assign ack       = wr_ack ? DIN[2:0] : 3'b000;

    assign AA_SPEED   = mode_q[15:8];
    assign AA_DISABLE = mode_q[MODE_AA_DIS];
    assign TIMER_MODE = mode_q[7:4];

    // MODE and RELOAD registers written from the 68k bus.
    always_ff @(posedge CLK or negedge RESETP) begin
        if (!RESETP) begin
            mode_q   <= '0;
            reload_q <= '0;
        end else begin
            if (wr_mode)
                mode_q <= DIN;
            if (wr_rld_hi)
                reload_q[TIMER_W-1:16] <= DIN[TIMER_W-17:0];
            if (wr_rld_lo)
                reload_q[15:0] <= DIN;
        end
    end

`ifdef LSPC_TIMER_STOP_EN
    logic tstop_q;

    // TSTOP register; the timer freezes only while the border is active.
    always_ff @(posedge CLK or negedge RESETP) begin
        if (!RESETP)
            tstop_q <= 1'b0;
        else if (WR && (ADDR == LSPC_REG_TSTOP))
            tstop_q <= DIN[0];
    end

    assign stop = tstop_q && PAL_BORDER;

    logic unused_bits;
    assign unused_bits = ^mode_q[2:0];
`else
    assign stop = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{mode_q[2:0], PAL_BORDER};
`endif

    lspc_timer_cnt #(
        .TIMER_W (TIMER_W)
    ) u_cnt (
        .CLK      (CLK),
        .RESETP   (RESETP),
        .wr_ld    (wr_rld_lo && mode_q[MODE_RLD_WR]),
        .wr_val   ({reload_q[TIMER_W-1:16], DIN}),
        .frame_ld (FRAME_START && mode_q[MODE_RLD_FRAME]),
        .reload   (reload_q),
        .rld_zero (mode_q[MODE_RLD_ZERO]),
        .tick     (PCK_EN),
        .stop     (stop),
        .zero_hit (zero_hit),
        .count    (count)
    );

    // Pending IRQ flags: a set event in the same cycle as its ack wins.
    always_ff @(posedge CLK or negedge RESETP) begin
        if (!RESETP) begin
            IRQ_TIMER <= 1'b0;
            IRQ_VBL   <= 1'b0;
            IRQ_RESET <= 1'b1;
        end else begin
            IRQ_TIMER <= (zero_hit && mode_q[MODE_TIRQ_EN]) || (IRQ_TIMER && !ack[ACK_TIMER]);
            IRQ_VBL   <= FRAME_START || (IRQ_VBL && !ack[ACK_VBL]);
            IRQ_RESET <= IRQ_RESET && !ack[ACK_RESET];
        end
    end

endmodule

// File: doc/lspc_irq_timer_ctrl.md
# lspc_irq_timer_ctrl

Configuration and interrupt controller for the LSPC register block, alongside the auto-animation counter. Decodes 68k writes to the LSPC mode, timer reload, IRQ-ack and timer-stop registers. Drives `AA_SPEED` and `AA_DISABLE` into the auto-animation path. Runs the 32-bit programmable raster timer and produces the three level-sensitive interrupt requests: timer, vblank and reset.

## Interface
Parameters:
- `TIMER_W`, default 32: timer counter and reload width.

Ports:
- `CLK`  in  1  system clock; the only clock.
- `RESETP`  in  1  reset, asynchronous, active-low.
- `PCK_EN`  in  1  pixel-clock enable, one CLK wide; timer tick.
- `FRAME_START`  in  1  one-CLK pulse at the first vblank line.
- `PAL_BORDER`  in  1  high during PAL border lines; used only with `LSPC_TIMER_STOP_EN`.
- `WR`  in  1  register write strobe, one CLK per access.
- `ADDR`  in  3  word offset from the LSPC base: 3=MODE, 4=RELOAD_HI, 5=RELOAD_LO, 6=IRQ_ACK, 7=TIMER_STOP. Other offsets are ignored.
- `DIN`  in  16  write data.
- `AA_SPEED`  out  8  auto-animation speed, `MODE[15:8]`.
- `AA_DISABLE`  out  1  `MODE[3]`.
- `TIMER_MODE`  out  4  `MODE[7:4]`, exported for debug readback.
- `IRQ_TIMER`, `IRQ_VBL`, `IRQ_RESET`  out  1 each  pending interrupt flags.

## Operation
- **Reset values**
  - MODE, RELOAD and counter = 0.
  - `IRQ_TIMER` = 0, `IRQ_VBL` = 0.
  - `IRQ_RESET` = 1: the cold-boot IRQ3 is pending until acknowledged.
- **MODE register**: the write stores all 16 bits. Bit meanings:
  - `[4]` timer IRQ enable.
  - `[5]` reload on RELOAD_LO write.
  - `[6]` reload at FRAME_START.
  - `[7]` reload on zero.
- **RELOAD_HI / RELOAD_LO**: write `RELOAD[31:16]` / `RELOAD[15:0]`. A RELOAD_LO write with `MODE[5]=1` also loads the counter with the new full 32-bit value.
- **IRQ_ACK**: `DIN[0]` clears RESET, `DIN[1]` clears TIMER, `DIN[2]` clears VBL. Zero bits have no effect.
- **Counter**: on each `PCK_EN`, counter == 0 is a zero-hit.
  - Zero-hit with `MODE[4]=1` sets `IRQ_TIMER`.
  - Zero-hit with `MODE[7]=1` loads RELOAD.
  - Zero-hit with `MODE[7]=0` wraps to all-ones.
  - Any other `PCK_EN` decrements the counter by 1, modulo 2^32.
- **FRAME_START**: sets `IRQ_VBL`. With `MODE[6]=1` it also loads the counter from RELOAD.
- **Counter-load priority**, highest first:
  1. RELOAD_LO write reload.
  2. FRAME_START reload.
  3. Zero-hit reload or decrement.
- A zero-hit in the same cycle as a write reload still raises `IRQ_TIMER` if enabled.
- **IRQ set vs ack**: a set event and an ack of the same flag in the same cycle leaves the flag set.
- **Disabling the timer IRQ**: `MODE[4]` going 0 does not clear a pending `IRQ_TIMER`.

## Timing
- Register writes are visible on outputs at N+1 for a write in cycle N.
- IRQ flags are registered. Each flag asserts the cycle after its `PCK_EN` zero-hit or `FRAME_START` pulse.
- The counter advances only on `PCK_EN`. Counter loads from writes or `FRAME_START` take effect at N+1 regardless of `PCK_EN`.
- Reset asserted mid-count returns everything to reset values asynchronously. The first tick is the first `PCK_EN` after deassertion.
- `AA_SPEED` is held stable between MODE writes, so the auto-animation prescaler sees a new value only from N+1.

## Configuration
- **`LSPC_TIMER_STOP_EN` defined**
  - Offset 7 stores `DIN[0]` as TSTOP; reset value 0.
  - While TSTOP=1 and `PAL_BORDER`=1, `PCK_EN` ticks are ignored: no decrement and no zero-hit.
  - Writes and `FRAME_START` loads still apply.
- **`LSPC_TIMER_STOP_EN` undefined**
  - Offset-7 writes are ignored, `PAL_BORDER` is unused, and the timer always runs.

## Structure
- Shared package `lspc_pkg` holds:
  - register offsets `LSPC_REG_MODE` … `LSPC_REG_TSTOP`;
  - MODE bit positions `MODE_TIRQ_EN`, `MODE_RLD_WR`, `MODE_RLD_FRAME`, `MODE_RLD_ZERO`, `MODE_AA_DIS`;
  - ack bit positions.
- One sub-module, `lspc_timer_cnt`, contains the counter: load/value/tick/stop inputs and a zero-hit output, with the load priority implemented inside it.
- Register decode and IRQ flags live in the top module.

## Test plan
- **Reset release**: `IRQ_RESET`=1 and all other outputs 0. Write ACK 0x0001 → `IRQ_RESET`=0 next cycle.
- **MODE write 0x3F08**: `AA_SPEED`=0x3F and `AA_DISABLE`=1 at N+1; `TIMER_MODE`=0.
- **Periodic timer**:
  - Setup: MODE=0x00B0, RELOAD_HI=0, RELOAD_LO=3; counter loads 3.
  - Stimulus: 4 `PCK_EN` ticks.
  - Expected: `IRQ_TIMER` rises after the 4th tick and the counter is 3 again.
  - Then ACK 0x0002 in the same cycle as the next zero-hit: the flag stays set.
- **Wrap without reload**:
  - MODE=0x0010, counter 0, one tick → `IRQ_TIMER`=1 and counter=0xFFFFFFFF.
  - Write RELOAD_LO in the same cycle as `FRAME_START` with `MODE[6:5]`=11 → counter takes the written value.
- **Vblank**: `FRAME_START` pulse → `IRQ_VBL`=1 at the next cycle. ACK 0x0004 clears it.
- **With `LSPC_TIMER_STOP_EN`**: TSTOP=1, `PAL_BORDER`=1, 10 ticks → counter unchanged. With `PAL_BORDER`=0 the counter decrements by 10.
